game_turn_ctrl: RTL
===================

// Module: game_turn_ctrl
// PURPOSE
// Turn sequencer for the 2048 core. Owns the 4x4 board register and the score.
// Per accepted direction command it runs: move/merge unit -> change check -> tile spawn unit -> win/lose check.
// Sits between button decode (dir_*) and the move and spawn datapaths (start/done handshakes); board_q also feeds the VGA renderer.
// PARAMETERS
// WIN_VALUE  12'h800  tile value that sets game_won
// TIMEOUT    1023     max cycles to wait for move_done/spawn_done before fault
// PORTS
// clk          in   1          system clock, all logic on posedge
// rst          in   1          synchronous, active-high reset
// new_game     in   1          1-cycle pulse: restart game, priority over everything except rst
// dir_valid    in   1          direction command valid
// dir          in   2          0=up 1=down 2=left 3=right
// dir_ready    out  1          1 only in IDLE with game_over=0; accept = dir_valid&dir_ready
// move_start   out  1          1-cycle pulse to move unit
// move_dir     out  2          direction, held stable from move_start until move_done
// move_done    in   1          move result valid this cycle
// move_board   in   12x[4][4]  moved/merged board, sampled when move_done=1
// move_pts     in   16         points from merges, sampled with move_done
// spawn_start  out  1          1-cycle pulse to tile spawn unit
// spawn_done   in   1          spawn result valid this cycle
// spawn_board  in   12x[4][4]  board with new tile, sampled when spawn_done=1
// board_q      out  12x[4][4]  current board (move/spawn input, display)
// score        out  16         accumulated score, saturates at 16'hFFFF
// busy         out  1          1 in every state except IDLE and OVER
// game_won     out  1          sticky until new_game/rst
// game_over    out  1          sticky until new_game/rst
// fault        out  1          sticky timeout flag, cleared by new_game/rst
// BEHAVIOUR
// - States: CLEAR, SPAWN_A, SPAWN_B, IDLE, MOVE, CMP, SPAWN, CHECK, OVER.
// - rst (sync): board_q=0, score=0, all flags=0, move_start=spawn_start=0, state=CLEAR.
// - CLEAR (1 cycle): board_q=0 -> SPAWN_A. SPAWN_A, SPAWN_B: pulse spawn_start on entry, wait spawn_done, load spawn_board -> next (SPAWN_B -> IDLE).
// - IDLE: on accept at cycle T, latch dir into move_dir; move_start=1 at T+1 (MOVE entry).
// - MOVE: wait move_done; capture move_board and move_pts into holding regs -> CMP.
// - CMP (1 cycle): if captured board == board_q: no change, score unchanged, -> IDLE with no spawn.
//   Otherwise board_q<=captured, score<=sat(score+move_pts), -> SPAWN.
//   A changed board always has >=1 empty cell, so spawn is always legal.
// - SPAWN: spawn_start pulse on entry; on spawn_done load board_q<=spawn_board -> CHECK.
// - CHECK (1 cycle): game_won|=any cell==WIN_VALUE.
//   Lose = no zero cell and no horizontally/vertically adjacent equal pair; if lose, game_over=1 -> OVER, else -> IDLE.
// - OVER: dir_ready=0, board and score frozen; only new_game/rst leave.
// - Winning does not stop play; game_won and game_over may both be 1.
// - Done pulses outside their wait state are ignored. Only one start is outstanding at a time.
// - Timeout: wait counter cleared on each start. If it reaches TIMEOUT in MOVE or SPAWN*:
//   fault=1, board_q/score unchanged by the pending op, -> IDLE.
// - new_game in any state (mid-MOVE/SPAWN included): score=0, flags=0, -> CLEAR next cycle.
//   Any later done from the aborted op is ignored.
// - new_game and dir accept in the same cycle: new_game wins, dir dropped.
// - Turn latency, 1-cycle units: accept T, move_start T+1, CMP T+3, spawn_start T+4, IDLE T+7.
// TESTING
// - Reset, spawn stub returns one 2-tile per call -> 2 spawn_start pulses; IDLE with exactly two nonzero cells, score=0, dir_ready=1.
// - Left on [2,2,0,0] row, stub move_pts=4 -> score=4, one spawn_start, busy back to 0 at T+7.
// - Move returns board identical to board_q -> no spawn_start, score unchanged, IDLE at T+4.
// - Spawn result is a full board with no adjacent equal pair -> game_over=1, dir_ready=0; dir_valid ignored; new_game recovers.
// - Move result contains 12'h800 -> game_won=1 after CHECK, play continues; score at 16'hFFF0 +32 -> 16'hFFFF.
// - Move stub never asserts done -> fault=1 after TIMEOUT cycles, board unchanged; new_game mid-MOVE -> CLEAR, late move_done ignored.

Source files
------------

// File: rtl/game_turn_ctrl.sv
// -----------------------------------------------------------------------------
// game_turn_ctrl
// Turn sequencer for the 2048 core. Owns the 4x4 board register and the score.
// One accepted direction command runs: move/merge unit -> change check ->
// tile spawn unit -> win/lose check. A new game clears the board and places
// two tiles through the spawn unit before play opens.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   new_game     1-cycle restart pulse, priority over everything but rst
//   dir_valid    direction command valid
//   dir          0=up 1=down 2=left 3=right
//   dir_ready    high in IDLE while the game is not over
//   move_start   1-cycle pulse to the move unit
//   move_dir     direction, stable from move_start until move_done
//   move_done    move result valid this cycle
//   move_board   moved/merged board, sampled with move_done
//   move_pts     merge points, sampled with move_done
//   spawn_start  1-cycle pulse to the tile spawn unit
//   spawn_done   spawn result valid this cycle
//   spawn_board  board with the new tile, sampled with spawn_done
//   board_q      current board (move/spawn input, display)
//   score        accumulated score, saturating at 16'hFFFF
//   busy         high in every state except IDLE and OVER
//   game_won     sticky: a WIN_VALUE tile has appeared
//   game_over    sticky: board full with no possible merge
//   fault        sticky: a move/spawn unit failed to answer within TIMEOUT
// -----------------------------------------------------------------------------
module game_turn_ctrl #(
    parameter logic [11:0] WIN_VALUE = 12'h800,
    parameter int          TIMEOUT   = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_game,
    input  logic                  dir_valid,
    input  logic [1:0]            dir,
    output logic                  dir_ready,
    output logic                  move_start,
    output logic [1:0]            move_dir,
    input  logic                  move_done,
    input  logic [3:0][3:0][11:0] move_board,
    input  logic [15:0]           move_pts,
    output logic                  spawn_start,
    input  logic                  spawn_done,
    input  logic [3:0][3:0][11:0] spawn_board,
    output logic [3:0][3:0][11:0] board_q,
    output logic [15:0]           score,
    output logic                  busy,
    output logic                  game_won,
    output logic                  game_over,
    output logic                  fault
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_CLEAR,
        S_SPAWN_A,
        S_SPAWN_B,
        S_IDLE,
        S_MOVE,
        S_CMP,
        S_SPAWN,
        S_CHECK,
        S_OVER
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0][3:0][11:0] r_board;
    logic [3:0][3:0][11:0] r_mv_board;
    logic [15:0]           r_score;
    logic [15:0]           r_mv_pts;
    logic [1:0]            r_move_dir;
    logic                  r_move_start;
    logic                  r_spawn_start;
    logic                  r_game_won;
    logic                  r_game_over;
    logic                  r_fault;
    logic [CW-1:0]         r_wait_cnt;

    logic w_accept;
    logic w_wait_state;
    logic w_timeout_hit;
    logic w_move_start_nxt;
    logic w_spawn_start_nxt;
    logic w_fault_set;
    logic w_changed;
    logic w_has_win;
    logic w_no_moves;

    function automatic logic f_has_value(input logic [3:0][3:0][11:0] b,
                                         input logic [11:0]           v);
        logic found;
        found = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[r][c] == v) found = 1'b1;
            end
        end
        return found;
    endfunction

    // Lose: no empty cell and no equal neighbour in either axis.
    function automatic logic f_no_moves(input logic [3:0][3:0][11:0] b);
        logic stuck;
        stuck = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[r][c] == 12'd0) stuck = 1'b0;
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (b[r][c] == b[r][c+1]) stuck = 1'b0;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[r][c] == b[r+1][c]) stuck = 1'b0;
            end
        end
        return stuck;
    endfunction

    function automatic logic [15:0] f_sat_add(input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign dir_ready     = (r_state == S_IDLE) && !r_game_over;
    assign w_accept      = dir_valid && dir_ready;
    assign w_wait_state  = (r_state == S_MOVE) || (r_state == S_SPAWN) ||
                           (r_state == S_SPAWN_A) || (r_state == S_SPAWN_B);
    assign w_timeout_hit = (r_wait_cnt == TO_LAST);
    assign w_changed     = (r_mv_board != r_board);
    assign w_has_win     = f_has_value(r_board, WIN_VALUE);
    assign w_no_moves    = f_no_moves(r_board);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_move_start_nxt  = 1'b0;
        w_spawn_start_nxt = 1'b0;
        w_fault_set       = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                w_state_nxt       = S_SPAWN_A;
                w_spawn_start_nxt = 1'b1;
            end
            S_SPAWN_A: begin
                if (spawn_done) begin
                    w_state_nxt       = S_SPAWN_B;
                    w_spawn_start_nxt = 1'b1;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_IDLE;
                    w_fault_set = 1'b1;
                end
            end
            S_SPAWN_B: begin
                if (spawn_done) begin
                    w_state_nxt = S_IDLE;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_IDLE;
                    w_fault_set = 1'b1;
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt      = S_MOVE;
                    w_move_start_nxt = 1'b1;
                end
            end
            S_MOVE: begin
                if (move_done) begin
                    w_state_nxt = S_CMP;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_IDLE;
                    w_fault_set = 1'b1;
                end
            end
            S_CMP: begin
                // An unchanged board is not a turn: no spawn, no score.
                if (w_changed) begin
                    w_state_nxt       = S_SPAWN;
                    w_spawn_start_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SPAWN: begin
                if (spawn_done) begin
                    w_state_nxt = S_CHECK;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_IDLE;
                    w_fault_set = 1'b1;
                end
            end
            S_CHECK: begin
                w_state_nxt = w_no_moves ? S_OVER : S_IDLE;
            end
            S_OVER: begin
                w_state_nxt = S_OVER;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
        // Restart overrides whatever the current state decided, including
        // a direction accepted in the same cycle.
        if (new_game) begin
            w_state_nxt       = S_CLEAR;
            w_move_start_nxt  = 1'b0;
            w_spawn_start_nxt = 1'b0;
            w_fault_set       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_board       <= '0;
            r_score       <= '0;
            r_game_won    <= 1'b0;
            r_game_over   <= 1'b0;
            r_fault       <= 1'b0;
            r_move_start  <= 1'b0;
            r_spawn_start <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_move_start  <= w_move_start_nxt;
            r_spawn_start <= w_spawn_start_nxt;
            // The wait counter restarts with every start pulse.
            if (w_move_start_nxt || w_spawn_start_nxt) begin
                r_wait_cnt <= '0;
            end else if (w_wait_state) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
            if (new_game) begin
                r_score     <= '0;
                r_game_won  <= 1'b0;
                r_game_over <= 1'b0;
                r_fault     <= 1'b0;
            end else begin
                if (w_fault_set) r_fault <= 1'b1;
                unique case (r_state)
                    S_CLEAR: begin
                        r_board <= '0;
                    end
                    S_SPAWN_A, S_SPAWN_B, S_SPAWN: begin
                        if (spawn_done) r_board <= spawn_board;
                    end
                    S_CMP: begin
                        if (w_changed) begin
                            r_board <= r_mv_board;
                            r_score <= f_sat_add(r_score, r_mv_pts);
                        end
                    end
                    S_CHECK: begin
                        if (w_has_win)  r_game_won  <= 1'b1;
                        if (w_no_moves) r_game_over <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Operand holding registers; their contents only matter in the states
    // that consume them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) r_move_dir <= dir;
        if ((r_state == S_MOVE) && move_done) begin
            r_mv_board <= move_board;
            r_mv_pts   <= move_pts;
        end
    end

    assign move_start  = r_move_start;
    assign move_dir    = r_move_dir;
    assign spawn_start = r_spawn_start;
    assign board_q     = r_board;
    assign score       = r_score;
    assign busy        = (r_state != S_IDLE) && (r_state != S_OVER);
    assign game_won    = r_game_won;
    assign game_over   = r_game_over;
    assign fault       = r_fault;

endmodule
